dac_serializer: RTL

Downstream of the Nyquist filter: accepts each decimated 24-bit sample on its one-cycle valid strobe and buffers it in a small FIFO. It re-times samples onto a left-justified, three-wire serial audio link (bit clock, word select, data) for an external DAC. Bit-clock rate and enable come from the standard block parameter memory. Samples are mono, and each sample is sent in both the left and right slots.

---
 rtl/dac_serializer_pkg.sv | 24 ++
 rtl/dac_serializer_fifo.sv | 68 ++++++
 rtl/dac_serializer.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/dac_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dac_serializer_pkg
// Description : Shared constants and helpers for the DAC serializer slice.
// Revision    : 1.0
// ============================================================================
package dac_serializer_pkg;

    localparam int unsigned ADDR_DIV  = 0;
    localparam int unsigned ADDR_CTRL = 1;
    localparam int unsigned ADDR_CLR  = 2;
    localparam int unsigned EN_BIT    = 0;
    localparam int unsigned DIV_WIDTH = 16;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // A programmed divider of zero behaves like one.
    function automatic logic [DIV_WIDTH-1:0] eff_div(input logic [DIV_WIDTH-1:0] div);
        return (div == '0) ? DIV_WIDTH'(1) : div;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dac_serializer_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sample_fifo
// Description : Synchronous FIFO with fall-through read data; a pop frees a
//               slot for a push on the same edge even when full.
// Revision    : 1.0
// ============================================================================
module sample_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic                       Clk_CI,
    input  logic                       Rst_RBI,
    input  logic                       Push_SI,
    input  logic                       Pop_SI,
    input  logic [WIDTH-1:0]           Din_DI,
    output logic [WIDTH-1:0]           Dout_DO,
    output logic                       Full_SO,
    output logic                       Empty_SO,
    output logic [$clog2(DEPTH):0]     Count_DO
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign Empty_SO = (count_q == '0);
    assign Full_SO  = (count_q == (PTR_W+1)'(DEPTH));
    assign Count_DO = count_q;
    assign Dout_DO  = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = Pop_SI & ~Empty_SO;
        do_push  = Push_SI & (~Full_SO | do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge Clk_CI) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= Din_DI;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dac_serializer.sv
`default_nettype none
// ============================================================================
// Module      : dac_serializer
// Description : Buffers mono samples and sends each one left-justified in
//               both slots of a bit-clock / word-select / data DAC link.
// Revision    : 1.0
// ============================================================================
module dac_serializer
    import dac_serializer_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int MEM_WIDTH  = 24,
    parameter int IN_WIDTH   = 24,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  Clk_CI,
    input  logic                  Rst_RBI,
    input  logic                  WrEn_SI,
    input  logic [ADDR_WIDTH-1:0] Addr_DI,
    input  logic [MEM_WIDTH-1:0]  PAR_In_DI,
    input  logic [IN_WIDTH-1:0]   SER_In_DI,
    input  logic                  SER_Valid_SI,
    output logic                  SER_Bclk_SO,
    output logic                  SER_Lrclk_SO,
    output logic                  SER_Data_SO,
    output logic                  SER_Overflow_SO,
    output logic                  SER_Underrun_SO
);

    localparam int CNT_W   = $clog2(2 * IN_WIDTH);
    localparam int BIT_W   = $clog2(IN_WIDTH);
    localparam int FCNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int MEM_N   = 2 ** ADDR_WIDTH;

    logic [MEM_WIDTH-1:0] par_mem_q [MEM_N];
    logic [DIV_WIDTH-1:0] cfg_div;
    logic                 en;
    logic                 clr;

    logic [0:0]           state_q, state_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IN_WIDTH-1:0]  hold_q, hold_d;
    logic                 bclk_q, bclk_d;
    logic                 lrclk_q, lrclk_d;
    logic                 data_q, data_d;
    logic                 ovf_q, ovf_d;
    logic                 udr_q, udr_d;

    logic                 frame_load;
    logic                 shift_out;
    logic [BIT_W-1:0]     slot_bit;

    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [IN_WIDTH-1:0]  fifo_dout;
    logic [FCNT_W-1:0]    fifo_count;

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            for (int i = 0; i < MEM_N; i++) begin
                par_mem_q[i] <= '0;
            end
        end else if (WrEn_SI) begin
            par_mem_q[Addr_DI] <= PAR_In_DI;
        end
    end

    assign cfg_div = par_mem_q[ADDR_DIV][DIV_WIDTH-1:0];
    assign en      = par_mem_q[ADDR_CTRL][EN_BIT];
    assign clr     = WrEn_SI && (Addr_DI == ADDR_WIDTH'(ADDR_CLR));

    sample_fifo #(
        .WIDTH (IN_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .Clk_CI   (Clk_CI),
        .Rst_RBI  (Rst_RBI),
        .Push_SI  (SER_Valid_SI),
        .Pop_SI   (fifo_pop),
        .Din_DI   (SER_In_DI),
        .Dout_DO  (fifo_dout),
        .Full_SO  (fifo_full),
        .Empty_SO (fifo_empty),
        .Count_DO (fifo_count)
    );

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (en)  state_d = ST_RUN;
            default: if (!en) state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        div_d      = div_q;
        div_cnt_d  = div_cnt_q;
        cnt_d      = cnt_q;
        hold_d     = hold_q;
        bclk_d     = bclk_q;
        lrclk_d    = lrclk_q;
        data_d     = data_q;
        frame_load = 1'b0;
        shift_out  = 1'b0;
        slot_bit   = '0;

        case (state_q)
            ST_IDLE: begin
                if (en) frame_load = 1'b1;
            end
            default: begin
                if (div_cnt_q == div_q - 1'b1) begin
                    div_cnt_d = '0;
                    if (!bclk_q) begin
                        bclk_d = 1'b1;
                    end else begin
                        // Falling edge of the bit clock advances to the next bit.
                        bclk_d    = 1'b0;
                        shift_out = 1'b1;
                        if (cnt_q == CNT_W'(2 * IN_WIDTH - 1)) begin
                            frame_load = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
        endcase

        if (!en) begin
            frame_load = 1'b0;
            shift_out  = 1'b0;
            div_cnt_d  = '0;
            cnt_d      = '0;
            hold_d     = '0;
            bclk_d     = 1'b0;
            lrclk_d    = 1'b0;
            data_d     = 1'b0;
        end

        if (frame_load) begin
            div_d     = eff_div(cfg_div);
            div_cnt_d = '0;
            cnt_d     = '0;
            bclk_d    = 1'b0;
            hold_d    = fifo_empty ? '0 : fifo_dout;
            shift_out = 1'b1;
        end

        if (shift_out) begin
            slot_bit = (cnt_d >= CNT_W'(IN_WIDTH)) ? BIT_W'(cnt_d - CNT_W'(IN_WIDTH))
                                                   : BIT_W'(cnt_d);
            lrclk_d  = (cnt_d >= CNT_W'(IN_WIDTH));
            data_d   = hold_d[BIT_W'(IN_WIDTH - 1) - slot_bit];
        end
    end

    assign fifo_pop = frame_load && (fifo_count != '0);

    // Setting a flag takes priority over a clear on the same edge.
    always_comb begin
        ovf_d = clr ? 1'b0 : ovf_q;
        udr_d = clr ? 1'b0 : udr_q;
        if (SER_Valid_SI && fifo_full && !fifo_pop) ovf_d = 1'b1;
        if (frame_load && fifo_empty)               udr_d = 1'b1;
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            div_q     <= '0;
            div_cnt_q <= '0;
            cnt_q     <= '0;
            hold_q    <= '0;
            bclk_q    <= 1'b0;
            lrclk_q   <= 1'b0;
            data_q    <= 1'b0;
            ovf_q     <= 1'b0;
            udr_q     <= 1'b0;
        end else begin
            div_q     <= div_d;
            div_cnt_q <= div_cnt_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            bclk_q    <= bclk_d;
            lrclk_q   <= lrclk_d;
            data_q    <= data_d;
            ovf_q     <= ovf_d;
            udr_q     <= udr_d;
        end
    end

    assign SER_Bclk_SO     = bclk_q;
    assign SER_Lrclk_SO    = lrclk_q;
    assign SER_Data_SO     = data_q;
    assign SER_Overflow_SO = ovf_q;
    assign SER_Underrun_SO = udr_q;

endmodule
`default_nettype wire
